sii_l2t_req_sched: RTL and testbench

SII_L2T_REQ_SCHED -- requirements
Module: sii_l2t_req_sched

---
 rtl/sii_l2t_pkg.sv | 22 ++
 rtl/sii_l2t_req_sched_if.sv | 37 +++
 rtl/sii_l2t_bank_seq.sv | 95 +++++++++
 rtl/sii_l2t_req_sched.sv | 93 +++++++++
 tb/tb_sii_l2t_req_sched.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sii_l2t_pkg.sv
// Shared types and sizes for the SII-to-L2T request scheduler and its per-bank sequencers.
package sii_l2t_pkg;

   localparam int NUM_BANKS = 8;
   localparam int HDR_W     = 64;
   localparam int BUS_W     = 32;
   localparam int BANK_W    = $clog2(NUM_BANKS);

   typedef enum logic [2:0] {
      IDLE,
      VLD,
      HDR0,
      HDR1,
      GAP
   } seqState_e;

   typedef enum logic {
      RR_DMU,
      RR_NIU
   } rrOwner_e;

endpackage

// File: rtl/sii_l2t_req_sched_if.sv
// Request/response bundle between the DMU/NIU requesters, the L2T banks and the scheduler.
interface sii_l2t_req_sched_if;
   import sii_l2t_pkg::*;

   logic                       dmu_req_vld;
   logic [BANK_W-1:0]          dmu_req_bank;
   logic [HDR_W-1:0]           dmu_req_hdr;
   logic                       dmu_req_rdy;

   logic                       niu_req_vld;
   logic [BANK_W-1:0]          niu_req_bank;
   logic [HDR_W-1:0]           niu_req_hdr;
   logic                       niu_req_rdy;

   logic [NUM_BANKS*BUS_W-1:0] sii_l2t_req;
   logic [NUM_BANKS-1:0]       sii_l2t_req_vld;
   logic [NUM_BANKS-1:0]       l2t_sii_iq_dequeue;
   logic [NUM_BANKS-1:0]       sii_credit_empty;
   logic [NUM_BANKS-1:0]       sii_credit_ovf;

   modport master (
      output dmu_req_vld, dmu_req_bank, dmu_req_hdr,
      output niu_req_vld, niu_req_bank, niu_req_hdr,
      output l2t_sii_iq_dequeue,
      input  dmu_req_rdy, niu_req_rdy,
      input  sii_l2t_req, sii_l2t_req_vld, sii_credit_empty, sii_credit_ovf
   );

   modport slave (
      input  dmu_req_vld, dmu_req_bank, dmu_req_hdr,
      input  niu_req_vld, niu_req_bank, niu_req_hdr,
      input  l2t_sii_iq_dequeue,
      output dmu_req_rdy, niu_req_rdy,
      output sii_l2t_req, sii_l2t_req_vld, sii_credit_empty, sii_credit_ovf
   );

endinterface

// File: rtl/sii_l2t_bank_seq.sv
// One L2T bank: VLD/HDR0/HDR1/GAP request sequencer plus its input-queue credit counter.
module sii_l2t_bank_seq
   import sii_l2t_pkg::*;
#(
   parameter int IQ_DEPTH   = 4,
   parameter int GAP_CYCLES = 3
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_accept,
   input  logic [HDR_W-1:0] i_hdr,
   input  logic             i_dequeue,
   output logic             o_idle,
   output logic             o_creditAvail,
   output logic [BUS_W-1:0] o_req,
   output logic             o_reqVld,
   output logic             o_creditEmpty,
   output logic             o_creditOvf
);

   localparam int                   GAP_CNT_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_CNT_W-1:0] GAP_LAST   = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [2:0]           CREDIT_MAX = 3'(IQ_DEPTH);

   seqState_e            r_state;
   seqState_e            w_stateNxt;
   logic [GAP_CNT_W-1:0] r_gapCnt;
   logic [HDR_W-1:0]     r_hdr;
   logic [2:0]           r_credit;
   logic                 r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_stateNxt;
   end

   always_comb begin
      w_stateNxt = r_state;
      case (r_state)
         IDLE:    if (i_accept) w_stateNxt = VLD;
         VLD:     w_stateNxt = HDR0;
         HDR0:    w_stateNxt = HDR1;
         HDR1:    w_stateNxt = (GAP_CYCLES == 0) ? IDLE : GAP;
         GAP:     if (r_gapCnt == '0) w_stateNxt = IDLE;
         default: w_stateNxt = IDLE;
      endcase
   end

   // GAP counts down from GAP_CYCLES-1 so the bank leaves GAP after exactly GAP_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gapCnt <= '0;
      end else if (r_state == HDR1) begin
         r_gapCnt <= GAP_LAST;
      end else if (r_state == GAP && r_gapCnt != '0) begin
         r_gapCnt <= r_gapCnt - GAP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_hdr <= '0;
      else if (i_accept) r_hdr <= i_hdr;
   end

   // A dequeue that would overflow the queue depth is absorbed and flagged instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credit <= CREDIT_MAX;
         r_ovf    <= 1'b0;
      end else begin
         case ({i_accept, i_dequeue})
            2'b10:   r_credit <= r_credit - 3'd1;
            2'b01: begin
               if (r_credit == CREDIT_MAX) r_ovf    <= 1'b1;
               else                        r_credit <= r_credit + 3'd1;
            end
            default: r_credit <= r_credit;
         endcase
      end
   end

   always_comb begin
      o_req = '0;
      if (r_state == HDR0)      o_req = r_hdr[HDR_W-1:BUS_W];
      else if (r_state == HDR1) o_req = r_hdr[BUS_W-1:0];
   end

   assign o_reqVld      = (r_state == VLD);
   assign o_idle        = (r_state == IDLE);
   assign o_creditAvail = (r_credit != 3'd0);
   assign o_creditEmpty = (r_credit == 3'd0);
   assign o_creditOvf   = r_ovf;

endmodule

// File: rtl/sii_l2t_req_sched.sv
// Arbitrates DMU and NIU header requests onto eight L2T banks with per-bank credit flow control.
module sii_l2t_req_sched
   import sii_l2t_pkg::*;
#(
   parameter int IQ_DEPTH   = 4,
   parameter int GAP_CYCLES = 3
)
(
   input  logic                iol2clk,
   input  logic                rst_l,
   sii_l2t_req_sched_if.slave  l2tBus
);

   logic [NUM_BANKS-1:0] w_bankIdle;
   logic [NUM_BANKS-1:0] w_bankCredit;
   logic [NUM_BANKS-1:0] w_bankAccept;
   logic [NUM_BANKS-1:0] w_bankReqVld;
   logic [NUM_BANKS-1:0] w_bankEmpty;
   logic [NUM_BANKS-1:0] w_bankOvf;
   logic [HDR_W-1:0]     w_bankHdr [NUM_BANKS];
   logic [BUS_W-1:0]     w_bankReq [NUM_BANKS];

   logic     w_dmuElig;
   logic     w_niuElig;
   logic     w_sameBank;
   logic     w_dmuGrant;
   logic     w_niuGrant;
   rrOwner_e r_rrPtr;

   // Eligibility is gated by rst_l so neither requester sees rdy while reset is held.
   always_comb begin
      w_dmuElig  = rst_l && l2tBus.dmu_req_vld &&
                   w_bankIdle[l2tBus.dmu_req_bank] && w_bankCredit[l2tBus.dmu_req_bank];
      w_niuElig  = rst_l && l2tBus.niu_req_vld &&
                   w_bankIdle[l2tBus.niu_req_bank] && w_bankCredit[l2tBus.niu_req_bank];
      w_sameBank = (l2tBus.dmu_req_bank == l2tBus.niu_req_bank);
      w_dmuGrant = w_dmuElig && !(w_niuElig && w_sameBank && r_rrPtr == RR_NIU);
      w_niuGrant = w_niuElig && !(w_dmuElig && w_sameBank && r_rrPtr == RR_DMU);
   end

   // The pointer moves on whenever its favoured requester wins, contested or not.
   always_ff @(posedge iol2clk or negedge rst_l) begin
      if (!rst_l) begin
         r_rrPtr <= RR_DMU;
      end else if (r_rrPtr == RR_DMU && w_dmuGrant) begin
         r_rrPtr <= RR_NIU;
      end else if (r_rrPtr == RR_NIU && w_niuGrant) begin
         r_rrPtr <= RR_DMU;
      end
   end

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_bankAccept[b] = (w_dmuGrant && l2tBus.dmu_req_bank == BANK_W'(b)) ||
                           (w_niuGrant && l2tBus.niu_req_bank == BANK_W'(b));
         w_bankHdr[b]    = (w_dmuGrant && l2tBus.dmu_req_bank == BANK_W'(b)) ?
                           l2tBus.dmu_req_hdr : l2tBus.niu_req_hdr;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sii_l2t_bank_seq #(
         .IQ_DEPTH   (IQ_DEPTH),
         .GAP_CYCLES (GAP_CYCLES)
      ) u_seq (
         .clk           (iol2clk),
         .rst_n         (rst_l),
         .i_accept      (w_bankAccept[b]),
         .i_hdr         (w_bankHdr[b]),
         .i_dequeue     (l2tBus.l2t_sii_iq_dequeue[b]),
         .o_idle        (w_bankIdle[b]),
         .o_creditAvail (w_bankCredit[b]),
         .o_req         (w_bankReq[b]),
         .o_reqVld      (w_bankReqVld[b]),
         .o_creditEmpty (w_bankEmpty[b]),
         .o_creditOvf   (w_bankOvf[b])
      );
   end

   always_comb begin
      l2tBus.sii_l2t_req = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         l2tBus.sii_l2t_req[b*BUS_W +: BUS_W] = w_bankReq[b];
      end
   end

   assign l2tBus.dmu_req_rdy      = w_dmuGrant;
   assign l2tBus.niu_req_rdy      = w_niuGrant;
   assign l2tBus.sii_l2t_req_vld  = w_bankReqVld;
   assign l2tBus.sii_credit_empty = w_bankEmpty;
   assign l2tBus.sii_credit_ovf   = w_bankOvf;

endmodule

// File: tb/tb_sii_l2t_req_sched.sv
// Directed and randomized bench for sii_l2t_req_sched against a cycle-level behavioural model.
module tb_sii_l2t_req_sched;

   localparam int IQ  = 4;
   localparam int GAP = 3;

   logic iol2clk = 1'b0;
   logic rst_l;

   sii_l2t_req_sched_if bus ();

   sii_l2t_req_sched #(
      .IQ_DEPTH   (IQ),
      .GAP_CYCLES (GAP)
   ) dut (
      .iol2clk (iol2clk),
      .rst_l   (rst_l),
      .l2tBus  (bus)
   );

   always #5 iol2clk = ~iol2clk;

   int checks = 0;
   int errors = 0;

   // Model: each bank remembers when it last accepted and when it may accept again.
   int          cyc;
   int          mCredit [8];
   bit          mOvf    [8];
   int          mFree   [8];
   int          mAcc    [8];
   bit          mActive [8];
   logic [63:0] mHdr    [8];
   bit          mFavNiu;
   bit          lastDGrant;
   bit          lastNGrant;
   logic        obsDmuRdy;
   logic        obsNiuRdy;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      cyc     = 0;
      mFavNiu = 1'b0;
      for (int b = 0; b < 8; b++) begin
         mCredit[b] = IQ;
         mOvf[b]    = 1'b0;
         mFree[b]   = 0;
         mAcc[b]    = 0;
         mActive[b] = 1'b0;
         mHdr[b]    = '0;
      end
   endtask

   task automatic checkOutput();
      logic [255:0] eReq;
      logic [7:0]   eVld;
      logic [7:0]   eEmpty;
      logic [7:0]   eOvf;
      eReq   = '0;
      eVld   = '0;
      eEmpty = '0;
      eOvf   = '0;
      for (int b = 0; b < 8; b++) begin
         if (mActive[b]) begin
            case (cyc - mAcc[b])
               1:       eVld[b] = 1'b1;
               2:       eReq[b*32 +: 32] = mHdr[b][63:32];
               3:       eReq[b*32 +: 32] = mHdr[b][31:0];
               default: ;
            endcase
         end
         eEmpty[b] = (mCredit[b] == 0);
         eOvf[b]   = mOvf[b];
      end
      chk("req_bus", bus.sii_l2t_req, eReq);
      chk("req_vld", bus.sii_l2t_req_vld, eVld);
      chk("credit_empty", bus.sii_credit_empty, eEmpty);
      chk("credit_ovf", bus.sii_credit_ovf, eOvf);
   endtask

   // Drives one cycle of inputs, checks this cycle's outputs, then advances the model.
   task automatic applyStimulus(input logic dv, input logic [2:0] db, input logic [63:0] dh,
                                input logic nv, input logic [2:0] nb, input logic [63:0] nh,
                                input logic [7:0] deq);
      bit dElig;
      bit nElig;
      bit acc;
      bus.dmu_req_vld        = dv;
      bus.dmu_req_bank       = db;
      bus.dmu_req_hdr        = dh;
      bus.niu_req_vld        = nv;
      bus.niu_req_bank       = nb;
      bus.niu_req_hdr        = nh;
      bus.l2t_sii_iq_dequeue = deq;
      #1;
      dElig      = dv && (cyc >= mFree[db]) && (mCredit[db] > 0);
      nElig      = nv && (cyc >= mFree[nb]) && (mCredit[nb] > 0);
      lastDGrant = dElig;
      lastNGrant = nElig;
      if (dElig && nElig && db == nb) begin
         lastDGrant = !mFavNiu;
         lastNGrant = mFavNiu;
      end
      checkOutput();
      obsDmuRdy = bus.dmu_req_rdy;
      obsNiuRdy = bus.niu_req_rdy;
      chk("dmu_rdy", obsDmuRdy, lastDGrant);
      chk("niu_rdy", obsNiuRdy, lastNGrant);
      if ((lastDGrant && !mFavNiu) || (lastNGrant && mFavNiu)) mFavNiu = !mFavNiu;
      if (lastDGrant) begin
         mActive[db] = 1'b1; mAcc[db] = cyc; mHdr[db] = dh; mFree[db] = cyc + 4 + GAP;
      end
      if (lastNGrant) begin
         mActive[nb] = 1'b1; mAcc[nb] = cyc; mHdr[nb] = nh; mFree[nb] = cyc + 4 + GAP;
      end
      for (int b = 0; b < 8; b++) begin
         acc = (lastDGrant && db == 3'(b)) || (lastNGrant && nb == 3'(b));
         if (acc && !deq[b]) begin
            mCredit[b]--;
         end else if (!acc && deq[b]) begin
            if (mCredit[b] == IQ) mOvf[b] = 1'b1;
            else                  mCredit[b]++;
         end
      end
      cyc++;
      @(negedge iol2clk);
   endtask

   task automatic idleStep();
      applyStimulus(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0, 8'd0);
   endtask

   task automatic doReset();
      rst_l = 1'b0;
      #1;
      chk("rst_req", bus.sii_l2t_req, '0);
      chk("rst_vld", bus.sii_l2t_req_vld, '0);
      chk("rst_empty", bus.sii_credit_empty, '0);
      chk("rst_ovf", bus.sii_credit_ovf, '0);
      chk("rst_dmu_rdy", bus.dmu_req_rdy, '0);
      chk("rst_niu_rdy", bus.niu_req_rdy, '0);
      modelReset();
      bus.dmu_req_vld        = 1'b0;
      bus.niu_req_vld        = 1'b0;
      bus.l2t_sii_iq_dequeue = '0;
      @(negedge iol2clk);
      @(negedge iol2clk);
      rst_l = 1'b1;
   endtask

   initial begin
      logic        dv;
      logic        nv;
      logic [2:0]  db;
      logic [2:0]  nb;
      logic [63:0] dh;
      logic [63:0] nh;
      logic [7:0]  deq;
      int          grants;

      rst_l                  = 1'b1;
      bus.dmu_req_vld        = 1'b1;
      bus.dmu_req_bank       = 3'd0;
      bus.dmu_req_hdr        = 64'h0;
      bus.niu_req_vld        = 1'b1;
      bus.niu_req_bank       = 3'd1;
      bus.niu_req_hdr        = 64'h0;
      bus.l2t_sii_iq_dequeue = 8'h00;
      #2;
      doReset();

      // Single DMU request on bank 2: header split across HDR0/HDR1, then GAP.
      applyStimulus(1'b1, 3'd2, 64'h1122334455667788, 1'b0, 3'd0, 64'd0, 8'd0);
      chk("r024_vld_t1", bus.sii_l2t_req_vld, 8'h04);
      idleStep();
      chk("r024_hdr_hi", bus.sii_l2t_req[95:64], 32'h11223344);
      idleStep();
      chk("r024_hdr_lo", bus.sii_l2t_req[95:64], 32'h55667788);
      for (int k = 0; k < 3; k++) begin
         idleStep();
         chk("r024_gap", bus.sii_l2t_req, '0);
      end

      // Same-bank contention after reset: DMU first, NIU when the bank frees at T+7.
      doReset();
      applyStimulus(1'b1, 3'd5, 64'hAAAA0001BBBB0001, 1'b1, 3'd5, 64'hCCCC0002DDDD0002, 8'd0);
      chk("r025_dmu_first", obsDmuRdy, 1'b1);
      chk("r025_niu_blocked", obsNiuRdy, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b0, 3'd0, 64'd0, 1'b1, 3'd5, 64'hCCCC0002DDDD0002, 8'd0);
         chk("r025_niu_wait", obsNiuRdy, 1'b0);
      end
      applyStimulus(1'b0, 3'd0, 64'd0, 1'b1, 3'd5, 64'hCCCC0002DDDD0002, 8'd0);
      chk("r025_niu_t7", obsNiuRdy, 1'b1);
      applyStimulus(1'b1, 3'd4, 64'h1234, 1'b1, 3'd4, 64'h5678, 8'd0);
      chk("r025_ptr_dmu", obsDmuRdy, 1'b1);
      chk("r025_ptr_niu", obsNiuRdy, 1'b0);

      // Different banks are accepted together.
      doReset();
      applyStimulus(1'b1, 3'd0, 64'h0F0F0F0F0F0F0F0F, 1'b1, 3'd7, 64'hF0F0F0F0F0F0F0F0, 8'd0);
      chk("r026_dmu_rdy", obsDmuRdy, 1'b1);
      chk("r026_niu_rdy", obsNiuRdy, 1'b1);
      chk("r026_vld_pair", bus.sii_l2t_req_vld, 8'h81);

      // Drain bank 3 credits, stall, then release with one dequeue.
      doReset();
      grants = 0;
      dh     = 64'hA5A5000000000000;
      for (int k = 0; k < 40 && grants < 4; k++) begin
         applyStimulus(1'b1, 3'd3, dh, 1'b0, 3'd0, 64'd0, 8'd0);
         if (lastDGrant) begin
            grants++;
            dh = dh + 64'h1;
         end
      end
      chk("r027_empty", bus.sii_credit_empty[3], 1'b1);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 3'd3, dh, 1'b0, 3'd0, 64'd0, 8'd0);
         chk("r027_stall", obsDmuRdy, 1'b0);
      end
      applyStimulus(1'b1, 3'd3, dh, 1'b0, 3'd0, 64'd0, 8'h08);
      chk("r027_deq_cycle", obsDmuRdy, 1'b0);
      applyStimulus(1'b1, 3'd3, dh, 1'b0, 3'd0, 64'd0, 8'h00);
      chk("r027_after_deq", obsDmuRdy, 1'b1);

      // Accept plus dequeue at full credit is neutral; a lone dequeue overflows.
      doReset();
      applyStimulus(1'b1, 3'd1, 64'h0101010101010101, 1'b0, 3'd0, 64'd0, 8'h02);
      chk("r028_acc_rdy", obsDmuRdy, 1'b1);
      chk("r028_no_ovf", bus.sii_credit_ovf[1], 1'b0);
      applyStimulus(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0, 8'h02);
      chk("r028_ovf_set", bus.sii_credit_ovf[1], 1'b1);
      idleStep();

      // Reset during HDR0 of bank 6 aborts the sequence and restores credit.
      doReset();
      applyStimulus(1'b1, 3'd6, 64'hDEADBEEFCAFEF00D, 1'b0, 3'd0, 64'd0, 8'd0);
      idleStep();
      chk("r029_hdr0", bus.sii_l2t_req[223:192], 32'hDEADBEEF);
      bus.dmu_req_vld  = 1'b1;
      bus.dmu_req_bank = 3'd6;
      doReset();
      idleStep();
      chk("r029_empty", bus.sii_credit_empty[6], 1'b0);
      chk("r029_req", bus.sii_l2t_req, '0);
      $display("[TB] directed steps complete, starting random traffic");

      // Random traffic on a narrow bank range to force frequent contention.
      doReset();
      dv = 1'b0;
      nv = 1'b0;
      db = 3'd0;
      nb = 3'd0;
      dh = '0;
      nh = '0;
      for (int k = 0; k < 600; k++) begin
         if (!dv && $urandom_range(0, 2) == 0) begin
            dv = 1'b1;
            db = 3'($urandom_range(0, 3));
            dh = {$urandom(), $urandom()};
         end
         if (!nv && $urandom_range(0, 2) == 0) begin
            nv = 1'b1;
            nb = 3'($urandom_range(0, 3));
            nh = {$urandom(), $urandom()};
         end
         deq = '0;
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 5) == 0) deq[b] = 1'b1;
         end
         applyStimulus(dv, db, dh, nv, nb, nh, deq);
         if (lastDGrant) dv = 1'b0;
         if (lastNGrant) nv = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
